// File: rtl/klingon_display_scanner_if.sv
// Display scanner bus: load handshake, shared-decoder link and display drive.
interface klingon_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load_req;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load_ack;
  logic [3:0]              dec_code;
  logic [6:0]              dec_y;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_tick;

  // System side: enables the scan, offers values, hosts the shared decoder.
  modport master (
    output en, load_req, digits_in, dec_y,
    input  load_ack, dec_code, seg_out, an_n, frame_tick
  );

  // Scanner side.
  modport slave (
    input  en, load_req, digits_in, dec_y,
    output load_ack, dec_code, seg_out, an_n, frame_tick
  );
endinterface

// File: rtl/klingon_display_scanner.sv
// Multiplexed common-anode display scanner sharing one 7-segment decoder.
// Each digit slot opens with blank guard cycles while the decoder settles,
// then lights the anode; new values are taken only at frame boundaries.
module klingon_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  klingon_display_scanner_if.slave  bus
);

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SH_W   = 4 * NUM_DIGITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] GUARD_LAST = SLOT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [1:0]            r_state;
  logic [SLOT_W-1:0]     r_slot;
  logic [IDX_W-1:0]      r_idx;
  logic [SH_W-1:0]       r_shadow;
  logic [3:0]            r_dec_code;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_ack;
  logic                  r_tick;

  logic [1:0]            w_nxt_state;
  logic [SLOT_W-1:0]     w_nxt_slot;
  logic [IDX_W-1:0]      w_nxt_idx;
  logic [SH_W-1:0]       w_nxt_shadow;
  logic [6:0]            w_nxt_seg;
  logic                  w_nxt_ack;
  logic [3:0]            w_nxt_code;
  logic [NUM_DIGITS-1:0] w_nxt_an_n;
  logic                  w_nxt_tick;
  logic                  w_frame_end;

  // Last SHOW cycle of the last digit: the only edge where a load may land while scanning.
  assign w_frame_end = (r_state == S_SHOW) && (r_idx == IDX_LAST) && (r_slot == SLOT_LAST);

  // Next-state scan sequencing, segment capture and frame-boundary load.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_slot   = r_slot;
    w_nxt_idx    = r_idx;
    w_nxt_seg    = r_seg;
    w_nxt_shadow = r_shadow;
    w_nxt_ack    = 1'b0;
    if (!bus.en) begin
      w_nxt_state = S_OFF;
      w_nxt_slot  = '0;
      w_nxt_idx   = '0;
      w_nxt_seg   = '0;
    end else begin
      case (r_state)
        S_GUARD: begin
          w_nxt_slot = r_slot + SLOT_W'(1);
          if (r_slot == GUARD_LAST) begin
            // Code has been on the decoder for at least one full cycle here.
            w_nxt_seg   = (r_dec_code > 4'd9) ? 7'd0 : bus.dec_y;
            w_nxt_state = S_SHOW;
          end
        end
        S_SHOW: begin
          if (r_slot == SLOT_LAST) begin
            w_nxt_slot  = '0;
            w_nxt_idx   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            w_nxt_state = S_GUARD;
          end else begin
            w_nxt_slot = r_slot + SLOT_W'(1);
          end
        end
        default: begin
          w_nxt_state = S_GUARD;
          w_nxt_slot  = '0;
          w_nxt_idx   = '0;
        end
      endcase
    end
    // Load is decided on the current state, so it still lands when en drops at frame end.
    if (bus.load_req && (w_frame_end || (r_state == S_OFF))) begin
      w_nxt_shadow = bus.digits_in;
      w_nxt_ack    = 1'b1;
    end
  end

  // Outputs are precomputed from next-state values so they register glitch-free.
  assign w_nxt_code = w_nxt_shadow[{w_nxt_idx, 2'b00} +: 4];
  assign w_nxt_an_n = (w_nxt_state == S_SHOW) ? ~(NUM_DIGITS'(1) << w_nxt_idx) : '1;
  assign w_nxt_tick = (w_nxt_state == S_SHOW) && (w_nxt_idx == IDX_LAST) &&
                      (w_nxt_slot == SLOT_LAST);

  // State and output registers; reset blanks the display without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_OFF;
      r_slot     <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_dec_code <= '0;
      r_seg      <= '0;
      r_an_n     <= '1;
      r_ack      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_slot     <= w_nxt_slot;
      r_idx      <= w_nxt_idx;
      r_shadow   <= w_nxt_shadow;
      r_dec_code <= w_nxt_code;
      r_seg      <= w_nxt_seg;
      r_an_n     <= w_nxt_an_n;
      r_ack      <= w_nxt_ack;
      r_tick     <= w_nxt_tick;
    end
  end

  assign bus.dec_code   = r_dec_code;
  assign bus.seg_out    = r_seg;
  assign bus.an_n       = r_an_n;
  assign bus.load_ack   = r_ack;
  assign bus.frame_tick = r_tick;

endmodule

// File: doc/klingon_display_scanner.md
Name: klingon_display_scanner

Overview:
- Time-multiplexes one shared Klingon_dataflow 7-segment decoder across NUM_DIGITS common-anode digit positions.
- Sequences the decoder's 4-bit code input and captures its Y output, with ghost-free blanking between digits.
- Drives active-low digit anodes.
- Accepts new display values through a req/ack handshake that is applied only at frame boundaries, so a frame never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
SLOT_CYCLES, 1000, clock cycles per digit slot (>= GUARD_CYCLES+2)
GUARD_CYCLES, 2, blank cycles at the start of each slot (>= 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = display off
load_req  in  1  requester asserts while digits_in is valid
digits_in  in  4*NUM_DIGITS  digit k code = digits_in[4k+3:4k]
load_ack  out  1  one-cycle pulse: digits_in captured
dec_code  out  4  to shared decoder; dec_code[3]->I0 (MSB), [2]->I1, [1]->I2, [0]->I3
dec_y  in  7  decoder Y output (combinational from dec_code)
seg_out  out  7  registered segment pattern for the active digit
an_n  out  NUM_DIGITS  active-low anode enables, at most one low at a time
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (async, rst_n=0):
  - an_n = all 1, seg_out = 0, dec_code = 0, load_ack = 0, frame_tick = 0.
  - Shadow digit register = 0, digit_idx = 0, slot_cnt = 0, state = OFF.
  - Reset mid-slot takes effect immediately, without waiting for a clock edge.
- States:
  - OFF: an_n all 1, counters held at 0. Leaves to GUARD when en=1.
  - GUARD: slot_cnt runs 0..GUARD_CYCLES-1.
    - an_n all 1.
    - dec_code = shadow[digit_idx] is registered and driven from slot_cnt=0.
    - At slot_cnt = GUARD_CYCLES-1, seg_out <= dec_y (code is stable at least one cycle). Transition to SHOW.
  - SHOW: slot_cnt runs GUARD_CYCLES..SLOT_CYCLES-1.
    - an_n[digit_idx] = 0, all other bits 1. seg_out held.
    - At slot_cnt = SLOT_CYCLES-1: slot_cnt <= 0, digit_idx <= (digit_idx+1) mod NUM_DIGITS, go to GUARD.
- en=0 in any state: next edge goes to OFF, an_n all 1, seg_out <= 0, slot_cnt and digit_idx <= 0. The shadow register is kept.
- On en 0->1: first frame starts at digit 0 in GUARD.
- Blanking of invalid codes: if shadow[digit_idx] > 9, seg_out <= 0 at the capture edge regardless of dec_y. The code is still presented on dec_code.
- Frame end: the SHOW cycle with digit_idx = NUM_DIGITS-1 and slot_cnt = SLOT_CYCLES-1.
  - frame_tick = 1 during exactly that cycle (registered, so it asserts the cycle the condition holds).
- Load handshake:
  - If load_req=1 at the frame-end edge: shadow <= digits_in, and load_ack = 1 for the following single cycle.
  - The new values appear from digit 0 of the next frame.
  - load_req sampled at any other edge is ignored.
  - A load_req still high at the next frame end is captured again, with another ack.
  - Requesters drop load_req on seeing load_ack.
  - In OFF, a load_req=1 is captured on the next edge, with a one-cycle ack.
- Period arithmetic:
  - Counters are wide enough for SLOT_CYCLES-1 and NUM_DIGITS-1 and wrap exactly at those bounds; no other wrap.
  - Frame period = NUM_DIGITS*SLOT_CYCLES cycles.
- Simultaneous events:
  - en falling at the frame-end edge: OFF wins for the scan, and the load is still captured and acked.
  - rst_n overrides everything.

Test Plan:
(Bench parameters: NUM_DIGITS=4, SLOT_CYCLES=8, GUARD_CYCLES=2; the real Klingon_dataflow drives dec_y.)
1. Reset then en=1 with shadow 0 -> an_n=1111 for 2 cycles; then an_n=1110 for 6 cycles; seg_out = decoder Y of code 0000; dec_code=0000.
2. With en=1, load_req=1, digits_in=16'h9_3_1_0 held until ack -> load_ack pulses exactly once, one cycle after frame_tick. The next frame shows dec_code 0,1,3,9 on an_n 1110,1101,1011,0111; frame_tick period is 32 cycles.
3. digits_in=16'hF_A_2_5 loaded -> digits 2 and 3 show seg_out=0000000 while dec_code=1010/1111; digits 0 and 1 show decoder Y for 0101 and 0010.
4. load_req pulsed high mid-frame for 3 cycles only (not spanning frame end) -> no load_ack; display unchanged.
5. en dropped mid-SHOW of digit 2 -> next edge an_n=1111, seg_out=0. en raised 5 cycles later -> restart at digit 0 with 2 guard cycles; shadow contents retained.
6. rst_n pulsed low mid-SHOW (between clock edges) -> an_n=1111, seg_out=0, load_ack=0 immediately. After release, shadow=0 and the scan resumes from digit 0 once en=1.
